lsu_handshake: RTL and testbench
================================

// Module: lsu_handshake
// PURPOSE
//  Parametrised load/store unit for the NPC core; replaces the current fixed, combinational memory path (wmask tied 0, single-cycle pmem access).
//  Accepts one load/store request per transaction from the core, drives a valid/ready memory port with byte mask and aligned address,
//  and returns sign/zero-extended load data or store completion on a response handshake. Supports XLEN 32/64 and a bus timeout.
// PARAMETERS
//  XLEN      32   data/address width; legal values 32 or 64
//  TIMEOUT   255  max cycles waiting on mem_ready/mem_rvalid before fault; 0 = no timeout
// PORTS
//  clk         in   1        clock, all state updates on posedge
//  rst         in   1        asynchronous, active-high reset
//  req_valid   in   1        core request valid
//  req_ready   out  1        LSU can accept request (high only in IDLE)
//  req_wen     in   1        1 = store, 0 = load
//  req_func3   in   3        RV func3: 000 b, 001 h, 010 w, 011 d (XLEN=64 only), 100 bu, 101 hu, 110 wu (XLEN=64 only)
//  req_addr    in   XLEN     byte address
//  req_wdata   in   XLEN     store data, right-justified
//  rsp_valid   out  1        response valid
//  rsp_ready   in   1        core accepts response
//  rsp_rdata   out  XLEN     extended load data; 0 for stores and faults
//  rsp_fault   out  1        misaligned / illegal func3 / timeout
//  mem_valid   out  1        memory command valid
//  mem_ready   in   1        memory accepts command
//  mem_wen     out  1        memory write
//  mem_addr    out  XLEN     req_addr with low log2(XLEN/8) bits cleared
//  mem_wdata   out  XLEN     store data shifted to byte lane
//  mem_wmask   out  XLEN/8   byte enables (stores; all-ones on loads)
//  mem_rvalid  in   1        load data valid
//  mem_rdata   in   XLEN     full aligned word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=0; mem_valid=0, mem_wen=0, mem_addr/wdata/wmask=0; timeout counter=0.
//  States: IDLE, ADDR, DATA, RSP. All outputs registered except req_ready (=state==IDLE).
//  IDLE: req_valid&req_ready captures request. Legal -> ADDR (mem_valid=1 next cycle). Illegal func3 (011/110 with XLEN=32, 111) -> RSP, fault=1.
//  ADDR: hold mem_valid and all mem_* stable until mem_ready. On mem_ready: store -> RSP; load -> DATA. mem_valid drops the cycle after.
//  DATA: wait mem_rvalid; capture mem_rdata >> (8*offset), extend per func3 (b/h/w signed, bu/hu/wu zero), -> RSP.
//  RSP: rsp_valid held with stable data/fault until rsp_ready; then -> IDLE, rsp_valid=0 next cycle. No new request accepted before then.
//  Min latency (accept edge = cycle 0): store rsp_valid cycle 2; load rsp_valid cycle 3 (mem_ready at 1, mem_rvalid at 2).
//  mem_rvalid in ADDR is ignored; mem_rvalid/mem_ready outside ADDR/DATA are ignored.
//  wmask: size mask (b=1,h=3,w=0xF,d=0xFF) << offset, truncated to XLEN/8 bits; wdata shifted by 8*offset.
//  Timeout: counter cleared on entering ADDR/DATA, increments each cycle in them; reaching TIMEOUT -> RSP, fault=1, rdata=0, mem_valid=0.
//  rst asserted mid-transaction: immediate return to reset values; in-flight memory command abandoned.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: address not naturally aligned to access size -> no memory command, IDLE -> RSP with fault=1, rdata=0.
//  Not defined: misaligned address is silently aligned down to access size (offset low bits cleared) and access proceeds; fault only for func3/timeout.
// TESTING
//  XLEN=32, lw addr 0x8000_0004, mem_rdata 0xDEAD_BEEF, mem_ready/rvalid immediate -> rsp_valid at cycle 3, rdata 0xDEADBEEF, fault 0.
//  lb addr 0x8000_0003, mem_rdata 0x80FF_0000 -> rdata 0xFFFF_FF80; lbu same -> 0x0000_0080; mem_addr 0x8000_0000.
//  sh addr 0x8000_0002, wdata 0x0000_1234 -> mem_wmask 4'b1100, mem_wdata 0x1234_xxxx lanes [31:16]=0x1234, rsp_valid cycle 2, rdata 0.
//  lw addr 0x8000_0002: with LSU_MISALIGN_TRAP_EN -> fault 1, mem_valid never asserted; without -> mem_addr 0x8000_0000, normal load.
//  TIMEOUT=4, mem_ready held 0 -> mem_valid high 4 cycles then 0, rsp_valid with fault 1; rsp_ready held 0 3 cycles -> outputs stable.
//  rst pulsed while in DATA -> all outputs at reset values next sample, req_ready=1; subsequent sw completes normally.

Source files
------------

// File: rtl/lsu_handshake.sv
// Load/store unit: one core request at a time, valid/ready memory port, registered response.
// Optional build macro LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module lsu_handshake #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_func3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a core request (req_ready high)
  // ADDR  | memory command presented, waiting for mem_ready
  // DATA  | load command accepted, waiting for mem_rvalid
  // RSP   | response presented, waiting for rsp_ready

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RSP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      func3_q, func3_d;
  logic [OFFW-1:0] off_q, off_d;

  logic            rsp_valid_d, rsp_fault_d, mem_valid_d, mem_wen_d;
  logic [XLEN-1:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;
  logic [NB-1:0]   mem_wmask_d;

  logic [OFFW-1:0] req_off, size_lsb, req_off_eff;
  logic [NB-1:0]   size_mask;
  logic            illegal, misalign, timeout_hit;
  logic [XLEN-1:0] addr_aligned, wdata_lane;
  logic [XLEN-1:0] rd_shift, rd_mask, rd_ext;
  logic            rd_sign;

  assign req_ready = (state == IDLE);

  // Request decode: access size, legality, alignment and byte-lane placement.
  always_comb begin
    req_off   = req_addr[OFFW-1:0];
    size_lsb  = '0;
    size_mask = '1;
    case (req_func3[1:0])
      2'b00: begin size_lsb = OFFW'(0); size_mask = NB'(1);  end
      2'b01: begin size_lsb = OFFW'(1); size_mask = NB'(3);  end
      2'b10: begin size_lsb = OFFW'(3); size_mask = NB'(15); end
      default: begin size_lsb = OFFW'(7); size_mask = '1;    end
    endcase
    illegal = (req_func3 == 3'b111) ||
              ((XLEN == 32) && ((req_func3 == 3'b011) || (req_func3 == 3'b110)));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = |(req_off & size_lsb);
`else
    misalign = 1'b0;
`endif
    req_off_eff  = req_off & ~size_lsb;
    addr_aligned = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    wdata_lane   = req_wdata << {req_off_eff, 3'b000};
  end

  // Load data: move the addressed lane down, then extend per the captured func3.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    rd_mask  = '1;
    rd_sign  = 1'b0;
    case (func3_q[1:0])
      2'b00: begin rd_mask = XLEN'(8'hFF);         rd_sign = rd_shift[7];  end
      2'b01: begin rd_mask = XLEN'(16'hFFFF);      rd_sign = rd_shift[15]; end
      2'b10: begin rd_mask = XLEN'(32'hFFFF_FFFF); rd_sign = rd_shift[31]; end
      default: begin rd_mask = '1;                 rd_sign = 1'b0;         end
    endcase
    rd_ext = (rd_shift & rd_mask) | ((!func3_q[2] && rd_sign) ? ~rd_mask : '0);
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    func3_d     = func3_q;
    off_d       = off_q;
    rsp_valid_d = rsp_valid;
    rsp_fault_d = rsp_fault;
    rsp_rdata_d = rsp_rdata;
    mem_valid_d = mem_valid;
    mem_wen_d   = mem_wen;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    case (state)
      IDLE: begin
        if (req_valid) begin
          func3_d = req_func3;
          off_d   = req_off_eff;
          if (illegal || misalign) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ADDR;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
            mem_addr_d  = addr_aligned;
            mem_wdata_d = req_wen ? wdata_lane : '0;
            mem_wmask_d = req_wen ? (size_mask << req_off_eff) : '1;
          end
        end
      end
      ADDR: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_wen) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end else if (timeout_hit) begin
          state_d     = RSP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (mem_rvalid) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = rd_ext;
        end else if (timeout_hit) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      func3_q   <= '0;
      off_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      func3_q   <= func3_d;
      off_q     <= off_d;
      rsp_valid <= rsp_valid_d;
      rsp_fault <= rsp_fault_d;
      rsp_rdata <= rsp_rdata_d;
      mem_valid <= mem_valid_d;
      mem_wen   <= mem_wen_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wmask <= mem_wmask_d;
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake (XLEN=32, TIMEOUT=4) with hand-computed expectations.
module tb_lsu_handshake;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_handshake #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Presents one request; returns #1 after the accept edge.
  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string name);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) begin $display("FAIL %s_rsp_drop: got %b want 0", name, rsp_valid); n_bad++; end n_cmp++;
    if (req_ready !== 1'b1) begin $display("FAIL %s_idle: got %b want 1", name, req_ready); n_bad++; end n_cmp++;
    rsp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (req_ready !== 1'b1) begin $display("FAIL rst_req_ready: got %b want 1", req_ready); n_bad++; end n_cmp++;
    if (rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
    if (mem_valid !== 1'b0) begin $display("FAIL rst_mem_valid: got %b want 0", mem_valid); n_bad++; end n_cmp++;
    if (mem_wmask !== 4'h0) begin $display("FAIL rst_wmask: got %h want 0", mem_wmask); n_bad++; end n_cmp++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_lw;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    if (mem_valid !== 1'b1) begin $display("FAIL lw_mem_valid: got %b want 1", mem_valid); n_bad++; end n_cmp++;
    if (mem_addr !== 32'h8000_0004) begin $display("FAIL lw_mem_addr: got %h want 80000004", mem_addr); n_bad++; end n_cmp++;
    if (mem_wmask !== 4'hF) begin $display("FAIL lw_wmask: got %h want f", mem_wmask); n_bad++; end n_cmp++;
    if (mem_wen !== 1'b0) begin $display("FAIL lw_wen: got %b want 0", mem_wen); n_bad++; end n_cmp++;
    if (req_ready !== 1'b0) begin $display("FAIL lw_busy: got %b want 0", req_ready); n_bad++; end n_cmp++;
    @(posedge clk); #1;
    if (mem_valid !== 1'b0) begin $display("FAIL lw_mem_drop: got %b want 0", mem_valid); n_bad++; end n_cmp++;
    if (rsp_valid !== 1'b0) begin $display("FAIL lw_rsp_early: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b1) begin $display("FAIL lw_rsp_c3: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin $display("FAIL lw_rdata: got %h want deadbeef", rsp_rdata); n_bad++; end n_cmp++;
    if (rsp_fault !== 1'b0) begin $display("FAIL lw_fault: got %b want 0", rsp_fault); n_bad++; end n_cmp++;
    finish_rsp("lw");
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002};
    logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
      issue(1'b0, f3[i], ad[i], 32'h0);
      if (mem_addr !== 32'h8000_0000) begin $display("FAIL ext%0d_mem_addr: got %h want 80000000", i, mem_addr); n_bad++; end n_cmp++;
      repeat (2) @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1) begin $display("FAIL ext%0d_rsp_valid: got %b want 1", i, rsp_valid); n_bad++; end n_cmp++;
      if (rsp_rdata !== ex[i]) begin $display("FAIL ext%0d_rdata: got %h want %h", i, rsp_rdata, ex[i]); n_bad++; end n_cmp++;
      finish_rsp("ext");
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3 [2] = '{3'b001, 3'b000};
    logic [31:0] ad [2] = '{32'h8000_0002, 32'h8000_0001};
    logic [31:0] wd [2] = '{32'h0000_1234, 32'h0000_00AB};
    logic [3:0]  wm [2] = '{4'b1100, 4'b0010};
    logic [31:0] wl [2] = '{32'h1234_0000, 32'h0000_AB00};
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      issue(1'b1, f3[i], ad[i], wd[i]);
      if (mem_wen !== 1'b1) begin $display("FAIL st%0d_wen: got %b want 1", i, mem_wen); n_bad++; end n_cmp++;
      if (mem_wmask !== wm[i]) begin $display("FAIL st%0d_wmask: got %b want %b", i, mem_wmask, wm[i]); n_bad++; end n_cmp++;
      if (mem_wdata !== wl[i]) begin $display("FAIL st%0d_wdata: got %h want %h", i, mem_wdata, wl[i]); n_bad++; end n_cmp++;
      if (mem_addr !== 32'h8000_0000) begin $display("FAIL st%0d_addr: got %h want 80000000", i, mem_addr); n_bad++; end n_cmp++;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1) begin $display("FAIL st%0d_rsp_c2: got %b want 1", i, rsp_valid); n_bad++; end n_cmp++;
      if (rsp_rdata !== 32'h0) begin $display("FAIL st%0d_rdata: got %h want 0", i, rsp_rdata); n_bad++; end n_cmp++;
      if (mem_valid !== 1'b0) begin $display("FAIL st%0d_mem_drop: got %b want 0", i, mem_valid); n_bad++; end n_cmp++;
      finish_rsp("st");
    end
  endtask

  task automatic test_misalign;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    issue(1'b0, 3'b010, 32'h8000_0002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    if (mem_valid !== 1'b0) begin $display("FAIL mis_mem_valid: got %b want 0", mem_valid); n_bad++; end n_cmp++;
    if (rsp_valid !== 1'b1) begin $display("FAIL mis_rsp_valid: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
    if (rsp_fault !== 1'b1) begin $display("FAIL mis_fault: got %b want 1", rsp_fault); n_bad++; end n_cmp++;
`else
    if (mem_addr !== 32'h8000_0000) begin $display("FAIL mis_addr: got %h want 80000000", mem_addr); n_bad++; end n_cmp++;
    repeat (2) @(posedge clk);
    #1;
    if (rsp_rdata !== 32'h1122_3344) begin $display("FAIL mis_rdata: got %h want 11223344", rsp_rdata); n_bad++; end n_cmp++;
    if (rsp_fault !== 1'b0) begin $display("FAIL mis_fault: got %b want 0", rsp_fault); n_bad++; end n_cmp++;
`endif
    finish_rsp("mis");
  endtask

  task automatic test_illegal;
    logic [2:0] f3 [2] = '{3'b011, 3'b111};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, f3[i], 32'h8000_0000, 32'h0);
      if (mem_valid !== 1'b0) begin $display("FAIL ill%0d_mem_valid: got %b want 0", i, mem_valid); n_bad++; end n_cmp++;
      if (rsp_valid !== 1'b1) begin $display("FAIL ill%0d_rsp_valid: got %b want 1", i, rsp_valid); n_bad++; end n_cmp++;
      if (rsp_fault !== 1'b1) begin $display("FAIL ill%0d_fault: got %b want 1", i, rsp_fault); n_bad++; end n_cmp++;
      finish_rsp("ill");
    end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (mem_valid !== 1'b1) begin $display("FAIL to_mem_valid%0d: got %b want 1", c, mem_valid); n_bad++; end n_cmp++;
      @(posedge clk); #1;
    end
    if (mem_valid !== 1'b0) begin $display("FAIL to_mem_drop: got %b want 0", mem_valid); n_bad++; end n_cmp++;
    for (int c = 0; c < 3; c++) begin
      if (rsp_valid !== 1'b1) begin $display("FAIL to_rsp_hold%0d: got %b want 1", c, rsp_valid); n_bad++; end n_cmp++;
      if (rsp_fault !== 1'b1) begin $display("FAIL to_fault_hold%0d: got %b want 1", c, rsp_fault); n_bad++; end n_cmp++;
      if (rsp_rdata !== 32'h0) begin $display("FAIL to_rdata_hold%0d: got %h want 0", c, rsp_rdata); n_bad++; end n_cmp++;
      @(posedge clk); #1;
    end
    finish_rsp("to");
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h5555_AAAA;
    issue(1'b0, 3'b010, 32'h8000_0020, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin $display("FAIL rm_req_ready: got %b want 1", req_ready); n_bad++; end n_cmp++;
    if (mem_addr !== 32'h0) begin $display("FAIL rm_mem_addr: got %h want 0", mem_addr); n_bad++; end n_cmp++;
    if (mem_wmask !== 4'h0) begin $display("FAIL rm_wmask: got %h want 0", mem_wmask); n_bad++; end n_cmp++;
    if (rsp_valid !== 1'b0) begin $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
    @(negedge clk) rst = 1'b0;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) begin $display("FAIL rm_no_stale: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
    mem_rvalid = 1'b0;
    issue(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D);
    if (mem_wmask !== 4'hF) begin $display("FAIL rm_sw_wmask: got %h want f", mem_wmask); n_bad++; end n_cmp++;
    if (mem_wdata !== 32'hCAFE_F00D) begin $display("FAIL rm_sw_wdata: got %h want cafef00d", mem_wdata); n_bad++; end n_cmp++;
    if (mem_addr !== 32'h8000_0008) begin $display("FAIL rm_sw_addr: got %h want 80000008", mem_addr); n_bad++; end n_cmp++;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b1) begin $display("FAIL rm_sw_rsp: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
    finish_rsp("rm");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset;
    test_lw;
    test_load_extend;
    test_store;
    test_misalign;
    test_illegal;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
